ucsbece154a_memarb: RTL and testbench
=====================================

# ucsbece154a_memarb

Two-requester arbiter for the single unified instruction/data memory of the multicycle RISC-V core. It shares the memory port between the processor datapath (fetch, load, store) and a debug/program-loader port. Each cycle it grants at most one requester, muxes that requester's address, write-enable and write data onto the memory, and routes the synchronous read data back with a valid strobe. It sits between the core's address mux (AdrSrc) and the memory; the controller treats a low `cpu_gnt_o` as a stall.

## Interface
- `ADDR_W`, 32, address width (byte address, passed through unchanged)
- `DATA_W`, 32, data width
- `MAX_BURST`, 4, maximum consecutive grants to one requester while the other is requesting; must be ≥1
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-low; `reset==0` at a rising edge resets all state
- `cpu_req_i`  in  1  CPU requests an access this cycle
- `cpu_we_i`  in  1  1 = write, 0 = read
- `cpu_addr_i`  in  ADDR_W  CPU address
- `cpu_wdata_i`  in  DATA_W  CPU write data
- `cpu_gnt_o`  out  1  CPU access accepted this cycle
- `cpu_rvalid_o`  out  1  CPU read data valid, one cycle after a granted read
- `cpu_rdata_o`  out  DATA_W  CPU read data
- `dbg_req_i`, `dbg_we_i`, `dbg_addr_i`, `dbg_wdata_i`  in  1/1/ADDR_W/DATA_W  debug port, same meaning as the CPU port
- `dbg_halt_i`  in  1  while 1, the CPU is never granted
- `dbg_gnt_o`, `dbg_rvalid_o`, `dbg_rdata_o`  out  1/1/DATA_W  debug port responses
- `mem_we_o`  out  1  memory write enable
- `mem_addr_o`  out  ADDR_W  memory address
- `mem_wdata_o`  out  DATA_W  memory write data
- `mem_rdata_i`  in  DATA_W  memory read data, registered inside the memory, valid one cycle after the address

## Operation
- Grant decision is combinational from the current requests, `dbg_halt_i`, and the registered state. At most one `*_gnt_o` is high; a grant is issued only to an active requester.
- Eligible requesters: CPU if `cpu_req_i & ~dbg_halt_i`; debug if `dbg_req_i`.
- If only one requester is eligible, it wins.
- If both are eligible:
  - The current owner keeps the port while `burst_cnt < MAX_BURST`.
  - Once `burst_cnt == MAX_BURST`, the other requester wins.
  - From IDLE, the CPU wins.
- The winner's `we`, `addr` and `wdata` drive `mem_*_o`. With no grant, `mem_we_o=0` and `mem_addr_o`/`mem_wdata_o` hold the CPU inputs.
- FSM with states IDLE, OWN_CPU, OWN_DBG (registered owner of the last granted cycle):
  - Any state → OWN_CPU on a CPU grant.
  - Any state → OWN_DBG on a debug grant.
  - Any state → IDLE when there is no grant.
- `burst_cnt` (width clog2(MAX_BURST)+1):
  - Set to 1 when the grant goes to a requester different from the current owner.
  - Incremented (saturating at MAX_BURST) when the same owner is granted again.
  - Cleared in IDLE.
- Read return: a registered `rd_owner` (NONE/CPU/DBG) is set from a granted read and NONE otherwise.
  - The next cycle, the matching `*_rvalid_o` is 1.
  - Both `*_rdata_o` outputs always carry `mem_rdata_i`; only the valid strobe is routed.
- Writes produce no rvalid.
- A requester keeps `req`, `we`, `addr` and `wdata` stable until granted; the arbiter does not queue requests.

## Timing
- Reset outputs: all `*_gnt_o`=0, `*_rvalid_o`=0, `mem_we_o`=0; state IDLE, `burst_cnt`=0, `rd_owner`=NONE. `reset` overrides the grant decision during the reset cycle.
- Grant latency is 0 cycles when uncontended. Read data latency is 1 cycle after the grant.
- Back-to-back grants to alternating owners are legal. An rvalid for cycle N's read coexists with cycle N+1's grant to the other port.
- Asserting `dbg_halt_i` mid-sequence:
  - Takes effect the same cycle.
  - A CPU read granted in the previous cycle still returns its rvalid.
- Reset mid-operation: any pending rvalid is dropped, and no rvalid is issued in the cycle after reset.
- `MAX_BURST=1` gives strict alternation under contention.

## Structure
- Shared package / defines file:
  - Owner encodings `owner_none`=2'b00, `owner_cpu`=2'b01, `owner_dbg`=2'b10.
  - Arbiter state encodings `arb_idle`, `arb_cpu`, `arb_dbg`.
- One natural sub-module, `ucsbece154a_memarb_rr`: the two-way fairness/burst counter that produces the winner select. The datapath muxes and rvalid routing stay in the top module.

## Test plan
- CPU-only read at `addr=0x10`, memory returns `0xDEADBEEF` → `cpu_gnt_o`=1 in cycle 0; `cpu_rvalid_o`=1 with `cpu_rdata_o=0xDEADBEEF` in cycle 1; `dbg_rvalid_o`=0.
- Both requesting continuously, `MAX_BURST=4`, starting from IDLE → grant sequence C,C,C,C,D,D,D,D,C,…
- `dbg_halt_i`=1, CPU requesting, debug writes `0x12345678` to `0x40` → `dbg_gnt_o`=1 and `mem_we_o`=1 with addr `0x40`; `cpu_gnt_o` stays 0 until halt is released, then is granted the same cycle.
- CPU read granted in cycle N, debug read granted in cycle N+1 → `cpu_rvalid_o` in N+1, `dbg_rvalid_o` in N+2, never both in the same cycle.
- `reset`=0 pulsed the cycle after a granted read → no rvalid; all outputs 0; next grant comes from IDLE with CPU priority.
- No requests → `mem_we_o`=0, both gnt=0, FSM in IDLE, `burst_cnt`=0.

Source files
------------

// File: rtl/ucsbece154a_memarb_pkg.sv
// ucsbece154a_memarb_pkg
// Shared encodings for the unified-memory arbiter:
//   owner_e     - who owns the read data returning next cycle (none/cpu/dbg)
//   arb_state_e - registered owner of the last granted cycle
package ucsbece154a_memarb_pkg;

  typedef enum logic [1:0] {
    owner_none = 2'b00,
    owner_cpu  = 2'b01,
    owner_dbg  = 2'b10
  } owner_e;

  typedef enum logic [1:0] {
    arb_idle = 2'b00,
    arb_cpu  = 2'b01,
    arb_dbg  = 2'b10
  } arb_state_e;

endpackage

// File: rtl/ucsbece154a_memarb_rr.sv
// ucsbece154a_memarb_rr
// Two-way fairness/burst tracker. Picks the winner among the eligible
// requesters: the current owner keeps the port for up to MAX_BURST
// consecutive grants while the other side is waiting; from idle the CPU wins.
// Ports:
//   clk, reset (sync, active-low)
//   cpu_elig, dbg_elig : requester eligible this cycle
//   cpu_win, dbg_win   : one-hot (or zero) winner select
module ucsbece154a_memarb_rr
  import ucsbece154a_memarb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_elig,
  input  logic dbg_elig,
  output logic cpu_win,
  output logic dbg_win
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  arb_state_e       state_reg, state_next;
  logic [CNT_W-1:0] burst_cnt_reg, burst_cnt_next;
  logic             burst_done;
  logic [CNT_W-1:0] burst_inc;

  assign burst_done = (burst_cnt_reg >= CNT_MAX);
  // Saturating increment so a lone requester never wraps the counter.
  assign burst_inc  = burst_done ? burst_cnt_reg : burst_cnt_reg + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= arb_idle;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  always_comb begin
    cpu_win        = 1'b0;
    dbg_win        = 1'b0;
    state_next     = arb_idle;
    burst_cnt_next = '0;

    if (cpu_elig && dbg_elig) begin
      // Contention: owner keeps the port until its burst is used up.
      case (state_reg)
        arb_cpu: begin
          if (burst_done) dbg_win = 1'b1;
          else            cpu_win = 1'b1;
        end
        arb_dbg: begin
          if (burst_done) cpu_win = 1'b1;
          else            dbg_win = 1'b1;
        end
        default: cpu_win = 1'b1;
      endcase
    end else begin
      cpu_win = cpu_elig;
      dbg_win = dbg_elig;
    end

    if (cpu_win) begin
      state_next     = arb_cpu;
      burst_cnt_next = (state_reg == arb_cpu) ? burst_inc : CNT_W'(1);
    end else if (dbg_win) begin
      state_next     = arb_dbg;
      burst_cnt_next = (state_reg == arb_dbg) ? burst_inc : CNT_W'(1);
    end
  end

endmodule

// File: rtl/ucsbece154a_memarb.sv
// ucsbece154a_memarb
// Arbiter for the single unified instruction/data memory of the multicycle
// RISC-V core. Shares the memory port between the CPU datapath and a
// debug/program-loader port, muxes the winner onto the memory and routes the
// one-cycle-late read data back with a valid strobe.
// Ports:
//   clk, reset (sync, active-low)
//   cpu_req_i/we_i/addr_i/wdata_i -> cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o
//   dbg_req_i/we_i/addr_i/wdata_i -> dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o
//   dbg_halt_i : blocks all CPU grants while high
//   mem_we_o, mem_addr_o, mem_wdata_o -> memory; mem_rdata_i <- memory (1-cycle)
module ucsbece154a_memarb
  import ucsbece154a_memarb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  input  logic              dbg_halt_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  logic   cpu_elig, dbg_elig;
  logic   cpu_win, dbg_win;
  owner_e rd_owner_reg, rd_owner_next;

  assign cpu_elig = cpu_req_i & ~dbg_halt_i;
  assign dbg_elig = dbg_req_i;

  ucsbece154a_memarb_rr #(
    .MAX_BURST(MAX_BURST)
  ) u_rr (
    .clk      (clk),
    .reset    (reset),
    .cpu_elig (cpu_elig),
    .dbg_elig (dbg_elig),
    .cpu_win  (cpu_win),
    .dbg_win  (dbg_win)
  );

  // Reset suppresses grants in the reset cycle itself.
  assign cpu_gnt_o = cpu_win & reset;
  assign dbg_gnt_o = dbg_win & reset;

  // Idle memory port parks on the CPU address/data with writes disabled.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = cpu_addr_i;
    mem_wdata_o = cpu_wdata_i;
    if (dbg_gnt_o) begin
      mem_we_o    = dbg_we_i;
      mem_addr_o  = dbg_addr_i;
      mem_wdata_o = dbg_wdata_i;
    end else if (cpu_gnt_o) begin
      mem_we_o    = cpu_we_i;
    end
  end

  always_comb begin
    rd_owner_next = owner_none;
    if (cpu_gnt_o && !cpu_we_i)      rd_owner_next = owner_cpu;
    else if (dbg_gnt_o && !dbg_we_i) rd_owner_next = owner_dbg;
  end

  always_ff @(posedge clk) begin
    if (!reset) rd_owner_reg <= owner_none;
    else        rd_owner_reg <= rd_owner_next;
  end

  // Gating with reset drops a read that was in flight when reset arrived.
  assign cpu_rvalid_o = reset & (rd_owner_reg == owner_cpu);
  assign dbg_rvalid_o = reset & (rd_owner_reg == owner_dbg);
  assign cpu_rdata_o  = mem_rdata_i;
  assign dbg_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_ucsbece154a_memarb.sv
module tb_ucsbece154a_memarb;

  localparam int MB = 4;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_halt;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_we;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  ucsbece154a_memarb #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_req_i    (cpu_req),
    .cpu_we_i     (cpu_we),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_gnt_o    (cpu_gnt),
    .cpu_rvalid_o (cpu_rvalid),
    .cpu_rdata_o  (cpu_rdata),
    .dbg_req_i    (dbg_req),
    .dbg_we_i     (dbg_we),
    .dbg_addr_i   (dbg_addr),
    .dbg_wdata_i  (dbg_wdata),
    .dbg_halt_i   (dbg_halt),
    .dbg_gnt_o    (dbg_gnt),
    .dbg_rvalid_o (dbg_rvalid),
    .dbg_rdata_o  (dbg_rdata),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'hA5A50000 | 32'(i));
  endfunction

  // Environment memory: synchronous read, 32 words.
  logic [31:0] mem [32];
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else begin
      if (mem_we) mem[mem_addr[6:2]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[6:2]];
    end
  end

  // Reference model state (plain integers: 0=none, 1=cpu, 2=dbg).
  logic [31:0] shadow [32];
  int          m_owner, m_cnt, m_rd, m_last_win;
  logic [31:0] m_rexp;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called mid-cycle: compare DUT outputs with the model, then advance it.
  task automatic model_step();
    int          win;
    bit          ce, de, ewe;
    logic [31:0] ea, ed;
    if (!reset) begin
      chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
      chk1("rst_dbg_gnt", dbg_gnt, 1'b0);
      chk1("rst_cpu_rvalid", cpu_rvalid, 1'b0);
      chk1("rst_dbg_rvalid", dbg_rvalid, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      m_owner = 0; m_cnt = 0; m_rd = 0; m_last_win = 0;
    end else begin
      ce = cpu_req && !dbg_halt;
      de = dbg_req;
      if (ce && de) begin
        if (m_owner == 2)      win = (m_cnt < MB) ? 2 : 1;
        else if (m_owner == 1) win = (m_cnt < MB) ? 1 : 2;
        else                   win = 1;
      end else begin
        win = ce ? 1 : (de ? 2 : 0);
      end
      ewe = (win == 1) ? cpu_we : ((win == 2) ? dbg_we : 1'b0);
      ea  = (win == 2) ? dbg_addr : cpu_addr;
      ed  = (win == 2) ? dbg_wdata : cpu_wdata;
      chk1("cpu_gnt", cpu_gnt, win == 1);
      chk1("dbg_gnt", dbg_gnt, win == 2);
      chk1("mem_we", mem_we, ewe);
      chk32("mem_addr", mem_addr, ea);
      chk32("mem_wdata", mem_wdata, ed);
      chk1("cpu_rvalid", cpu_rvalid, m_rd == 1);
      chk1("dbg_rvalid", dbg_rvalid, m_rd == 2);
      if (m_rd == 1) chk32("cpu_rdata", cpu_rdata, m_rexp);
      if (m_rd == 2) chk32("dbg_rdata", dbg_rdata, m_rexp);
      if (win != 0)
        $display("txn t=%0t port=%s we=%0b addr=%h wdata=%h", $time,
                 (win == 1) ? "cpu" : "dbg", ewe, ea, ed);
      if (win == 0)            m_cnt = 0;
      else if (win == m_owner) m_cnt = (m_cnt + 1 > MB) ? MB : m_cnt + 1;
      else                     m_cnt = 1;
      m_owner    = win;
      m_last_win = win;
      m_rd       = (win != 0 && !ewe) ? win : 0;
      if (m_rd != 0) m_rexp = shadow[ea[6:2]];
      if (win != 0 && ewe) shadow[ea[6:2]] = ed;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    cpu_req = 1'b0; cpu_we = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
  endtask

  logic [9:0] burst_pat;

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = init_word(i);
    m_owner = 0; m_cnt = 0; m_rd = 0; m_last_win = 0; m_rexp = '0;
    burst_pat = 10'b1111000011;
    reset = 1'b0; dbg_halt = 1'b0;
    set_idle();
    cpu_addr = '0; cpu_wdata = '0; dbg_addr = '0; dbg_wdata = '0;
    cpu_req = 1'b1;  // requests must be ignored while in reset
    @(posedge clk);
    #1;
    chk1("lit_rst_cpu_gnt", cpu_gnt, 1'b0);
    chk1("lit_rst_mem_we", mem_we, 1'b0);
    chk1("lit_rst_cpu_rvalid", cpu_rvalid, 1'b0);
    cycle();
    cycle();

    // No requests.
    reset = 1'b1;
    set_idle();
    #1;
    chk1("lit_idle_cpu_gnt", cpu_gnt, 1'b0);
    chk1("lit_idle_dbg_gnt", dbg_gnt, 1'b0);
    chk1("lit_idle_mem_we", mem_we, 1'b0);
    cycle();

    // CPU-only read of 0x10.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    #1;
    chk1("lit_rd_cpu_gnt", cpu_gnt, 1'b1);
    cycle();
    set_idle();
    #1;
    chk1("lit_rd_cpu_rvalid", cpu_rvalid, 1'b1);
    chk32("lit_rd_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk1("lit_rd_dbg_rvalid", dbg_rvalid, 1'b0);
    cycle();

    // Continuous contention from idle.
    cpu_req = 1'b1; cpu_addr = 32'h08;
    dbg_req = 1'b1; dbg_addr = 32'h0C;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk1("lit_burst_cpu_gnt", cpu_gnt, burst_pat[9-k]);
      chk1("lit_burst_dbg_gnt", dbg_gnt, !burst_pat[9-k]);
      cycle();
    end
    set_idle();
    cycle();

    // Halted CPU, debug writes 0x12345678 to 0x40.
    dbg_halt = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h40; dbg_wdata = 32'h12345678;
    #1;
    chk1("lit_halt_dbg_gnt", dbg_gnt, 1'b1);
    chk1("lit_halt_mem_we", mem_we, 1'b1);
    chk32("lit_halt_mem_addr", mem_addr, 32'h40);
    chk32("lit_halt_mem_wdata", mem_wdata, 32'h12345678);
    chk1("lit_halt_cpu_gnt", cpu_gnt, 1'b0);
    cycle();
    dbg_req = 1'b0; dbg_we = 1'b0;
    #1;
    chk1("lit_halt_cpu_blocked", cpu_gnt, 1'b0);
    cycle();
    dbg_halt = 1'b0;
    #1;
    chk1("lit_unhalt_cpu_gnt", cpu_gnt, 1'b1);
    cycle();
    set_idle();
    cycle();

    // CPU read in N, debug read in N+1.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    #1;
    chk1("lit_alt_cpu_gnt", cpu_gnt, 1'b1);
    cycle();
    cpu_req = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
    #1;
    chk1("lit_alt_dbg_gnt", dbg_gnt, 1'b1);
    chk1("lit_alt_cpu_rvalid", cpu_rvalid, 1'b1);
    chk1("lit_alt_dbg_rvalid0", dbg_rvalid, 1'b0);
    cycle();
    set_idle();
    #1;
    chk1("lit_alt_dbg_rvalid", dbg_rvalid, 1'b1);
    chk1("lit_alt_cpu_rvalid0", cpu_rvalid, 1'b0);
    chk32("lit_alt_dbg_rdata", dbg_rdata, 32'h12345678);
    cycle();

    // Reset pulsed right after a granted read.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    #1;
    chk1("lit_mrst_cpu_gnt", cpu_gnt, 1'b1);
    cycle();
    reset = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h44;
    #1;
    chk1("lit_mrst_cpu_rvalid", cpu_rvalid, 1'b0);
    chk1("lit_mrst_cpu_gnt0", cpu_gnt, 1'b0);
    chk1("lit_mrst_dbg_gnt0", dbg_gnt, 1'b0);
    cycle();
    reset = 1'b1;
    #1;
    chk1("lit_post_cpu_rvalid", cpu_rvalid, 1'b0);
    chk1("lit_post_dbg_rvalid", dbg_rvalid, 1'b0);
    chk1("lit_post_cpu_gnt", cpu_gnt, 1'b1);
    chk1("lit_post_dbg_gnt", dbg_gnt, 1'b0);
    cycle();
    set_idle();
    cycle();

    // Randomized traffic; a requester holds its request until granted.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 9) == 0) dbg_halt = ~dbg_halt;
      if (!cpu_req || m_last_win == 1) begin
        cpu_req   = ($urandom_range(0, 2) != 0);
        cpu_we    = ($urandom_range(0, 3) == 0);
        cpu_addr  = 32'($urandom_range(0, 31)) << 2;
        cpu_wdata = $urandom;
      end
      if (!dbg_req || m_last_win == 2) begin
        dbg_req   = ($urandom_range(0, 2) != 0);
        dbg_we    = ($urandom_range(0, 2) == 0);
        dbg_addr  = 32'($urandom_range(0, 31)) << 2;
        dbg_wdata = $urandom;
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
